instr_fetch_unit: RTL and testbench

- IF stage: owns the PC, issues reads to instruction memory and presents pc_out/instr_out/busywait to the IF/ID pipeline register.
- Handles instruction-memory wait states, hazard stalls from ID and branch/jump redirects from EX.
- Includes a one-entry hold buffer so an instruction that returns during a stall is not re-fetched.

---
 rtl/instr_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, issues reads to the
//            instruction memory, absorbs memory wait states, ID hazard
//            stalls and EX branch/jump redirects, and presents
//            pc_out/instr_out/busywait to the IF/ID pipeline register.
//            A one-entry hold buffer keeps an instruction that returns
//            during a stall so it is not fetched twice.
// Ports    : clk, rst (async, active-high)
//            stall, redirect, redirect_pc            - pipeline control in
//            mem_read, mem_address                   - instruction memory req
//            mem_readdata, mem_busywait              - instruction memory rsp
//            pc_out, instr_out, busywait             - to IF/ID register
//            perf_fetch_count, perf_stall_count      - only with
//                                                      FETCH_PERF_CNT_EN
// Options  : define FETCH_PERF_CNT_EN to add the two performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_read,
   output logic [31:0] mem_address,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetch_count,
   output logic [31:0] perf_stall_count,
`endif
   output logic        busywait
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_FETCH = 2'd1;
   localparam logic [1:0] c_HOLD  = 2'd2;
   localparam logic [1:0] c_DRAIN = 2'd3;

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_buf;
   logic [31:0] r_buf_pc;   // PC of buffered word in HOLD; stale read address in DRAIN

   logic [1:0]  w_next_state;
   logic [31:0] w_next_pc;
   logic [31:0] w_next_buf;
   logic [31:0] w_next_buf_pc;
   logic [31:0] w_target;
   logic        w_present;  // a real fetched word is handed to IF/ID this cycle

   assign w_target = {redirect_pc[31:2], 2'b00};

   always_comb begin
      w_next_state  = r_state;
      w_next_pc     = r_pc;
      w_next_buf    = r_buf;
      w_next_buf_pc = r_buf_pc;
      w_present     = 1'b0;
      mem_read      = 1'b0;
      mem_address   = r_pc;
      pc_out        = r_pc;
      instr_out     = NOP_INSTR;
      busywait      = 1'b1;

      case (r_state)
         c_IDLE: begin
            w_next_state = c_FETCH;
         end

         c_FETCH: begin
            mem_read = 1'b1;
            if (redirect) begin
               // Bubble into IF/ID; an in-flight read must be drained first,
               // so remember its address for the DRAIN request.
               busywait      = 1'b0;
               w_next_pc     = w_target;
               w_next_buf_pc = r_pc;
               w_next_state  = mem_busywait ? c_DRAIN : c_FETCH;
            end else if (!mem_busywait) begin
               if (!stall) begin
                  busywait  = 1'b0;
                  instr_out = mem_readdata;
                  w_present = 1'b1;
                  w_next_pc = r_pc + 32'd4;
               end else begin
                  w_next_buf    = mem_readdata;
                  w_next_buf_pc = r_pc;
                  w_next_state  = c_HOLD;
               end
            end
         end

         c_HOLD: begin
            if (redirect) begin
               busywait     = 1'b0;
               w_next_pc    = w_target;
               w_next_state = c_FETCH;
            end else if (!stall) begin
               busywait     = 1'b0;
               pc_out       = r_buf_pc;
               instr_out    = r_buf;
               w_present    = 1'b1;
               w_next_pc    = r_buf_pc + 32'd4;
               w_next_state = c_FETCH;
            end
         end

         default: begin // c_DRAIN
            // Keep the abandoned request stable until memory completes it;
            // its data is thrown away.
            mem_read    = 1'b1;
            mem_address = r_buf_pc;
            if (redirect) begin
               busywait  = 1'b0;
               w_next_pc = w_target;
            end
            // A redirect arriving on the completing cycle must not reissue
            // the stale read, so leave DRAIN as soon as memory is ready.
            if (!mem_busywait) begin
               w_next_state = c_FETCH;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= c_IDLE;
         r_pc     <= RESET_PC;
         r_buf    <= NOP_INSTR;
         r_buf_pc <= RESET_PC;
      end else begin
         r_state  <= w_next_state;
         r_pc     <= w_next_pc;
         r_buf    <= w_next_buf;
         r_buf_pc <= w_next_buf_pc;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (w_present && !busywait && (instr_out != NOP_INSTR)) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (busywait && (r_state != c_IDLE)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign perf_fetch_count = r_fetch_cnt;
   assign perf_stall_count = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit. Instruction
//            memory returns address + 0x100; wait states are driven per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam logic [31:0] c_NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_read;
   logic [31:0] mem_address;
   logic [31:0] mem_readdata;
   logic        mem_busywait;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        busywait;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_count;
   logic [31:0] perf_stall_count;
`endif

   int n_cmp;
   int n_err;

   instr_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (c_NOP)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait),
      .pc_out       (pc_out),
      .instr_out    (instr_out),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetch_count (perf_fetch_count),
      .perf_stall_count (perf_stall_count),
`endif
      .busywait     (busywait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: mem[a] = a + 0x100
   assign mem_readdata = mem_address + 32'h100;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs just after the falling edge, then settle.
   task automatic drive(input logic s, input logic r, input logic [31:0] rpc, input logic mbw);
      @(negedge clk);
      stall        = s;
      redirect     = r;
      redirect_pc  = rpc;
      mem_busywait = mbw;
      #1;
   endtask

   task automatic expect_present(input string tag, input logic [31:0] pc);
      check_val({tag, "_bw"},    {31'd0, busywait}, 32'd0);
      check_val({tag, "_pc"},    pc_out, pc);
      check_val({tag, "_instr"}, instr_out, pc + 32'h100);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; mem_busywait = 1'b0;
      #1;
      check_val("rst_mem_read", {31'd0, mem_read}, 32'd0);
      check_val("rst_busywait", {31'd0, busywait}, 32'd1);
      check_val("rst_instr",    instr_out, c_NOP);
      check_val("rst_pc",       pc_out, 32'd0);

      // Release reset; one IDLE cycle follows.
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("idle_busywait", {31'd0, busywait}, 32'd1);
      check_val("idle_mem_read", {31'd0, mem_read}, 32'd0);

      // Zero-wait streaming: pc 0,4,8,12
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b0);
         check_val("stream_addr", mem_address, 32'(i * 4));
         expect_present("stream", 32'(i * 4));
      end

      // Three wait cycles at pc=16
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b1);
         check_val("wait_addr",  mem_address, 32'd16);
         check_val("wait_bw",    {31'd0, busywait}, 32'd1);
         check_val("wait_instr", instr_out, c_NOP);
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      check_val("wait_addr4", mem_address, 32'd16);
      expect_present("wait_done", 32'd16);

      // Stall coinciding with response for pc=20, held 3 cycles
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      check_val("stall_resp_bw", {31'd0, busywait}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 32'd0, 1'b0);
         check_val("hold_mem_read", {31'd0, mem_read}, 32'd0);
         check_val("hold_bw",       {31'd0, busywait}, 32'd1);
         check_val("hold_instr",    instr_out, c_NOP);
      end
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      check_val("hold_rel_mem_read", {31'd0, mem_read}, 32'd0);
      expect_present("hold_rel", 32'd20);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      check_val("after_hold_addr", mem_address, 32'd24);
      expect_present("after_hold", 32'd24);

      // Redirect while read of pc=28 pending
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      check_val("pend_bw", {31'd0, busywait}, 32'd1);
      drive(1'b0, 1'b1, 32'h203, 1'b1);
      check_val("redir_bw",    {31'd0, busywait}, 32'd0);
      check_val("redir_instr", instr_out, c_NOP);
      check_val("redir_pc",    pc_out, 32'd28);
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      check_val("drain_mem_read", {31'd0, mem_read}, 32'd1);
      check_val("drain_addr",     mem_address, 32'd28);
      check_val("drain_bw",       {31'd0, busywait}, 32'd1);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      check_val("drain_done_addr",  mem_address, 32'd28);
      check_val("drain_done_instr", instr_out, c_NOP);
      check_val("drain_done_bw",    {31'd0, busywait}, 32'd1);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      check_val("target_addr", mem_address, 32'h200);
      expect_present("target", 32'h200);

      // Stall and redirect together: redirect wins, no HOLD
      drive(1'b1, 1'b1, 32'h40, 1'b0);
      check_val("sr_bw",    {31'd0, busywait}, 32'd0);
      check_val("sr_instr", instr_out, c_NOP);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      check_val("sr_mem_read", {31'd0, mem_read}, 32'd1);
      check_val("sr_addr",     mem_address, 32'h40);
      expect_present("sr_fetch", 32'h40);

      // PC wrap at 2^32
      drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      expect_present("wrap_top", 32'hFFFF_FFFC);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      check_val("wrap_addr", mem_address, 32'd0);

      // Async reset in the middle of DRAIN
      drive(1'b0, 1'b1, 32'h80, 1'b1);
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      check_val("pre_rst_drain_read", {31'd0, mem_read}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_val("async_rst_mem_read", {31'd0, mem_read}, 32'd0);
      check_val("async_rst_pc",       pc_out, 32'd0);
      check_val("async_rst_bw",       {31'd0, busywait}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      mem_busywait = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      check_val("post_rst_addr", mem_address, 32'd0);
      expect_present("post_rst", 32'd0);

`ifdef FETCH_PERF_CNT_EN
      // Fresh reset, 10 zero-wait fetches then a 3-cycle stall
      @(negedge clk);
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'd0, 1'b0);
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      check_val("perf_fetch", perf_fetch_count, 32'd10);
      check_val("perf_stall", perf_stall_count, 32'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
